// File: rtl/mem_port_arbiter.sv
// Single-port memory arbiter between instruction fetch (read-only) and data access (read/write).
// Data wins by default; an instruction request starved for STREAK data grants is forced through.
module mem_port_arbiter #(
   parameter int LAT    = 2,
   parameter int STREAK = 4
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        i_req,
   input  logic [31:0] i_addr,
   output logic [31:0] i_rdata,
   output logic        i_done,
   input  logic        d_req,
   input  logic        d_wen,
   input  logic [31:0] d_addr,
   input  logic [31:0] d_wdata,
   output logic [31:0] d_rdata,
   output logic        d_done,
   output logic        mem_en,
   output logic        mem_wen,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   input  logic [31:0] mem_rdata,
   output logic        busy,
   output logic [1:0]  owner
);

   typedef enum logic [1:0] {S_IDLE, S_I_RD, S_D_RD, S_D_WR} state_t;

   localparam logic [3:0] LAT_C    = 4'(LAT);
   localparam logic [3:0] STREAK_C = 4'(STREAK);
   localparam logic [1:0] OWN_NONE = 2'b00;
   localparam logic [1:0] OWN_I    = 2'b01;
   localparam logic [1:0] OWN_D    = 2'b10;

   state_t      r_state;
   logic [3:0]  r_cnt;
   logic [3:0]  r_streak;
   logic [31:0] r_i_rdata, r_d_rdata, r_mem_addr, r_mem_wdata;
   logic        r_i_done, r_d_done, r_mem_en, r_mem_wen, r_busy;
   logic [1:0]  r_owner;

   logic        w_grant_d;
   logic        w_done_now;

   assign w_grant_d  = d_req && !(i_req && (r_streak == STREAK_C));
   assign w_done_now = r_i_done || r_d_done;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state     <= S_IDLE;
         r_cnt       <= '0;
         r_streak    <= '0;
         r_i_rdata   <= '0;
         r_d_rdata   <= '0;
         r_mem_addr  <= '0;
         r_mem_wdata <= '0;
         r_i_done    <= 1'b0;
         r_d_done    <= 1'b0;
         r_mem_en    <= 1'b0;
         r_mem_wen   <= 1'b0;
         r_busy      <= 1'b0;
         r_owner     <= OWN_NONE;
      end else begin
         r_mem_en  <= 1'b0;
         r_mem_wen <= 1'b0;
         r_i_done  <= 1'b0;
         r_d_done  <= 1'b0;
         case (r_state)
            S_IDLE: begin
               // A done cycle never grants so a requester still holding req is not re-served.
               if (!w_done_now) begin
                  if (w_grant_d) begin
                     r_state     <= d_wen ? S_D_WR : S_D_RD;
                     r_mem_en    <= 1'b1;
                     r_mem_wen   <= d_wen;
                     r_mem_addr  <= d_addr;
                     r_mem_wdata <= d_wdata;
                     r_cnt       <= LAT_C;
                     r_busy      <= 1'b1;
                     r_owner     <= OWN_D;
                     if (!i_req)
                        r_streak <= '0;
                     else if (r_streak != STREAK_C)
                        r_streak <= r_streak + 4'd1;
                  end else if (i_req) begin
                     r_state    <= S_I_RD;
                     r_mem_en   <= 1'b1;
                     r_mem_addr <= i_addr;
                     r_cnt      <= LAT_C;
                     r_busy     <= 1'b1;
                     r_owner    <= OWN_I;
                     r_streak   <= '0;
                  end
               end
            end
            S_I_RD, S_D_RD: begin
               // Counter reaches zero in the cycle mem_rdata is valid.
               if (r_cnt == 4'd0) begin
                  if (r_state == S_I_RD) begin
                     r_i_rdata <= mem_rdata;
                     r_i_done  <= 1'b1;
                  end else begin
                     r_d_rdata <= mem_rdata;
                     r_d_done  <= 1'b1;
                  end
                  r_state <= S_IDLE;
                  r_busy  <= 1'b0;
                  r_owner <= OWN_NONE;
               end else begin
                  r_cnt <= r_cnt - 4'd1;
               end
            end
            S_D_WR: begin
               r_d_done <= 1'b1;
               r_state  <= S_IDLE;
               r_busy   <= 1'b0;
               r_owner  <= OWN_NONE;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign i_rdata   = r_i_rdata;
   assign i_done    = r_i_done;
   assign d_rdata   = r_d_rdata;
   assign d_done    = r_d_done;
   assign mem_en    = r_mem_en;
   assign mem_wen   = r_mem_wen;
   assign mem_addr  = r_mem_addr;
   assign mem_wdata = r_mem_wdata;
   assign busy      = r_busy;
   assign owner     = r_owner;

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-port memory between the instruction-fetch requester (read-only) and the data-access requester (read/write) of the pipelined CPU.
- Sequences each transaction through a small FSM with a fixed, parameterised memory read latency.
- Returns per-requester done pulses and read data. The CPU stages stall on req && !done.
- Data has priority, with a starvation guard for instruction fetch.

Parameters:
- LAT, 2, memory read latency in cycles from issue cycle to valid mem_rdata; legal 1..15
- STREAK, 4, max consecutive data grants while i_req is pending before instruction is forced; legal 1..15

Ports:
- clk  in  1  clock, all state on rising edge
- reset  in  1  asynchronous, active-low reset
- i_req  in  1  instruction read request, held until i_done
- i_addr  in  32  instruction address, stable while i_req high
- i_rdata  out  32  instruction read data, valid with i_done, held afterwards
- i_done  out  1  one-cycle completion pulse, instruction port
- d_req  in  1  data request, held until d_done
- d_wen  in  1  1 = write, 0 = read; stable while d_req high
- d_addr  in  32  data address
- d_wdata  in  32  write data
- d_rdata  out  32  data read data, valid with d_done, held afterwards
- d_done  out  1  one-cycle completion pulse, data port
- mem_en  out  1  memory access strobe, one cycle per transaction
- mem_wen  out  1  memory write enable, qualified by mem_en
- mem_addr  out  32  memory address
- mem_wdata  out  32  memory write data
- mem_rdata  in  32  memory read data, valid LAT cycles after mem_en cycle
- busy  out  1  FSM not in IDLE
- owner  out  2  00 none, 01 instruction, 10 data

Behaviour:
- Reset (reset low, asynchronous, immediate):
  - FSM goes to IDLE.
  - mem_en, mem_wen, i_done, d_done = 0.
  - mem_addr, mem_wdata, i_rdata, d_rdata = 0.
  - Streak counter = 0, owner = 00.
  - An in-flight transaction is abandoned: no done is produced for it after reset release.
- FSM states: IDLE, I_RD, D_RD, D_WR.
- IDLE, grant cycle G (only if no done pulse is being asserted this cycle):
  - If d_req and not (i_req and streak==STREAK): grant data.
    - Latch d_addr/d_wdata/d_wen into registers.
    - Next state D_WR if d_wen else D_RD.
    - Streak: +1 if i_req is high, else cleared.
  - Else if i_req: grant instruction.
    - Latch i_addr.
    - Next state I_RD, streak cleared.
  - Else stay in IDLE.
- Done-cycle rule: the cycle in which i_done or d_done is high never grants. The requester must drop or change req by the following cycle. This prevents a stale regrant.
- Issue cycle E = G+1:
  - mem_en = 1 for exactly this cycle.
  - mem_addr and mem_wdata come from the latched registers; mem_wen = latched wen in D states.
  - mem_addr and mem_wdata hold their values until the next issue.
- Write (D_WR): the memory commits at the end of E. d_done = 1 in E+1, FSM in IDLE at E+1. Total G→done = 2 cycles. d_rdata is unchanged.
- Read (I_RD/D_RD):
  - A down-counter is loaded with LAT at E.
  - At the end of cycle E+LAT, mem_rdata is captured into the owning port's rdata register.
  - done = 1 in E+LAT+1, FSM in IDLE then. Total G→done = LAT+2 cycles.
- owner and busy are registered and reflect the state from E through the last state cycle. Both read 00/0 in IDLE.
- If req drops mid-transaction, the transaction completes and done still pulses. If addr changes mid-transaction, the change is ignored (latched copy is used).
- i_done and d_done are never high in the same cycle. At most one transaction is in flight.
- Streak counter saturates at STREAK. A forced instruction grant clears it.

Test Plan:
- LAT=2, i_req=1, i_addr=0x10 at G, memory returns 0xDEADBEEF → mem_en=1, mem_addr=0x10, mem_wen=0 at G+1; i_done=1, i_rdata=0xDEADBEEF at G+4; no grant at G+4.
- i_req and d_req (read, 0x200) raised in the same cycle → data served first (mem_addr=0x200 at G+1, d_done at G+4); instruction issued at G+6 (G+4 no-grant done cycle, G+5 grant), i_done at G+9.
- d_req, d_wen=1, d_addr=0x40, d_wdata=0xCAFEF00D → mem_en=mem_wen=1 with those values at G+1; d_done at G+2; d_rdata unchanged.
- STREAK=4, i_req and d_req held high continuously, each req re-raised after its done → grant order D,D,D,D,I,D,...; owner sequence confirms it.
- reset pulled low in cycle E+1 of a read → all outputs 0 immediately, FSM IDLE; after release with no req, no done ever pulses.
- d_req dropped at E of a read → d_done still pulses at E+LAT+1 with captured data.
